cpu_instr_sequencer: RTL
========================

Name: cpu_instr_sequencer

Overview:
- Initiator for the lab CPU's instruction-load/start handshake (in, load, s, w).
- Holds a small program memory and issues each instruction in turn: drives the word, pulses load, raises s, then waits for w to fall and rise again.
- Captures the CPU result and flags after each instruction.
- Sits between the board-level I/O (or a testbench) and the cpu block.

Parameters:
- AW, 4: program address width; memory depth is 2**AW words of 16 bits.
- TIMEOUT, 64: maximum cycles spent in any CPU wait state before the block flags an error.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- prog_we  in  1  program-memory write strobe; honoured only while idle
- prog_addr  in  AW  program write address
- prog_data  in  16  instruction word to write
- go  in  1  start the run; sampled only in IDLE
- n_instr  in  AW+1  number of instructions to run, 0..2**AW
- cpu_in  out  16  instruction word to the CPU
- cpu_load  out  1  instruction-register load strobe to the CPU
- cpu_s  out  1  start request to the CPU
- cpu_w  in  1  CPU waiting flag (registered inside the CPU)
- cpu_out  in  16  CPU datapath output
- cpu_N, cpu_V, cpu_Z  in  1 each  CPU status flags
- res_valid  out  1  one-cycle pulse: result captured
- res_idx  out  AW  index of the instruction that produced the result
- res_out  out  16  captured cpu_out
- res_nzv  out  3  captured {N,V,Z}
- busy  out  1  high from go acceptance until DONE or ERR
- done  out  1  one-cycle pulse at successful run completion
- err  out  1  sticky timeout flag; cleared by reset or next accepted go

Behaviour:
- Reset values:
  - All outputs are 0: cpu_in, cpu_load, cpu_s, res_*, busy, done, err.
  - State is IDLE; pc=0; the timeout counter is 0.
  - Program memory is not reset.
- All outputs are registered. State and pc update only on the rising edge of clk.
- Registers: pc (AW+1 bits), cnt (timeout counter, saturating), latched count N (AW+1 bits, taken from n_instr at go).
- States and transitions:
  - IDLE:
    - prog_we writes mem[prog_addr].
    - On go: latch N, clear err, set pc=0, busy=1.
    - If N==0, go to FIN; otherwise go to LOAD.
  - LOAD: cpu_in=mem[pc], cpu_load=1 for exactly one cycle; then go to ARM.
  - ARM:
    - Wait for cpu_w==1, then go to START.
    - cpu_in is held stable from LOAD through COMPLETE.
  - START:
    - cpu_s=1, held until cpu_w==0 is sampled; cpu_s is deasserted in the same edge as the move to RUN.
    - cpu_s must never be high while the CPU is back in its wait state after finishing, so no double start.
  - RUN:
    - Wait for cpu_w==1.
    - On that edge, capture res_out=cpu_out and res_nzv={cpu_N,cpu_V,cpu_Z}, set res_idx=pc[AW-1:0], pulse res_valid for 1 cycle, pc=pc+1.
    - Then go to COMPLETE.
  - COMPLETE: if pc==N go to FIN, else go to LOAD.
  - FIN: done=1 for one cycle, busy=0; go to IDLE.
  - ERR:
    - Entered from ARM, START or RUN when cnt reaches TIMEOUT.
    - err=1, busy=0, cpu_s=0, cpu_load=0; go to IDLE.
- Timeout: cnt clears on every state change and increments each cycle spent in ARM, START or RUN.
- Per-instruction latency: minimum 1 (LOAD) + 1 (ARM) + 2 (START, since cpu_w falls 2 edges after s) + CPU execute cycles + 1 (COMPLETE).
- Boundary rules:
  - prog_we outside IDLE is ignored; memory is unchanged.
  - go while busy is ignored.
  - go together with prog_we in IDLE: the write completes, and the run starts the next cycle with the updated word.
  - pc width AW+1 allows N=2**AW without wrap. n_instr>2**AW is clamped to 2**AW.
  - Reset mid-run: immediate return to IDLE with reset values. No done or res_valid pulse is issued for the aborted instruction.
  - done and err are never both asserted for the same run.

Test Plan:
- Load mem[0..2] = 0xD007 (MOV R0,#7), 0xD102 (MOV R1,#2), 0xA140 (ADD R2,R1,R0); go with n_instr=3 -> exactly 3 res_valid pulses with res_idx 0,1,2; third res_out=0x0009; then done pulse and busy=0.
- Append 0xA801 (CMP R0,R1) as a 4th instruction; run with n_instr=4 -> fourth res_nzv={N=0,V=0,Z=0}; in a second run with 0xA800 (CMP R0,R0), Z=1.
- go with n_instr=0 -> done pulses 2 cycles after go; cpu_load and cpu_s never assert.
- CPU model holds cpu_w=0 forever after start -> err=1 within TIMEOUT+1 cycles in RUN; busy=0; cpu_s=0; no done; next go clears err.
- prog_we to address 0 during a run -> mem[0] unchanged; a rerun reproduces the first result. go while busy -> no restart and res_idx sequence uninterrupted.
- Assert reset in RUN of instruction 1 -> next cycle all outputs 0 and state IDLE; a subsequent go reruns from pc=0 with program memory intact.

Source files
------------

// File: rtl/cpu_instr_sequencer.sv
// Instruction sequencer for the lab CPU: stores a small program and feeds it to
// the CPU one word at a time over the in/load/s/w handshake, capturing each result.
module cpu_instr_sequencer #(
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          go,
  input  logic [AW:0]   n_instr,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  input  logic          cpu_w,
  input  logic [15:0]   cpu_out,
  input  logic          cpu_N,
  input  logic          cpu_V,
  input  logic          cpu_Z,
  output logic          res_valid,
  output logic [AW-1:0] res_idx,
  output logic [15:0]   res_out,
  output logic [2:0]    res_nzv,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    dbg_state
);

  // CPU handshake: cpu_in is held and cpu_load pulses for one cycle; once cpu_w
  // is high, cpu_s is raised and held until cpu_w is seen low (CPU accepted);
  // the next rising cpu_w marks the result on cpu_out/N/V/Z as valid.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   MAX_N  = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_START, S_RUN, S_COMPLETE, S_FIN, S_ERR
  } state_t;

  logic [15:0] mem [2**AW];

  state_t        state_q, state_d;
  logic [AW:0]   pc_q, pc_d;
  logic [AW:0]   n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   cpu_in_q, cpu_in_d;
  logic          cpu_load_q, cpu_load_d;
  logic          cpu_s_q, cpu_s_d;
  logic          res_valid_q, res_valid_d;
  logic [AW-1:0] res_idx_q, res_idx_d;
  logic [15:0]   res_out_q, res_out_d;
  logic [2:0]    res_nzv_q, res_nzv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          wr_en, timed_out, waiting;

  assign wr_en     = (state_q == S_IDLE) && prog_we;
  assign timed_out = (cnt_q == TO_LIM);
  assign waiting   = (state_q == S_ARM) || (state_q == S_START) || (state_q == S_RUN);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    n_d         = n_q;
    cpu_in_d    = cpu_in_q;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    res_out_d   = res_out_q;
    res_nzv_d   = res_nzv_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          n_d     = (n_instr > MAX_N) ? MAX_N : n_instr;
          err_d   = 1'b0;
          pc_d    = '0;
          busy_d  = 1'b1;
          state_d = (n_d == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: state_d = S_ARM;
      S_ARM: begin
        if (cpu_w)          state_d = S_START;
        else if (timed_out) state_d = S_ERR;
      end
      S_START: begin
        if (!cpu_w)         state_d = S_RUN;
        else if (timed_out) state_d = S_ERR;
      end
      S_RUN: begin
        if (cpu_w) begin
          res_valid_d = 1'b1;
          res_idx_d   = pc_q[AW-1:0];
          res_out_d   = cpu_out;
          res_nzv_d   = {cpu_N, cpu_V, cpu_Z};
          pc_d        = pc_q + (AW+1)'(1);
          state_d     = S_COMPLETE;
        end else if (timed_out) begin
          state_d = S_ERR;
        end
      end
      S_COMPLETE: state_d = (pc_q == n_q) ? S_FIN : S_LOAD;
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERR) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
    end

    // A write in the same cycle as go must reach the CPU, so bypass the array.
    if (state_d == S_LOAD)
      cpu_in_d = (wr_en && (prog_addr == pc_d[AW-1:0])) ? prog_data : mem[pc_d[AW-1:0]];

    cpu_load_d = (state_d == S_LOAD);
    cpu_s_d    = (state_d == S_START);

    if (state_d != state_q)             cnt_d = '0;
    else if (waiting && !timed_out)     cnt_d = cnt_q + CW'(1);
    else                                cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      cpu_in_q    <= '0;
      cpu_load_q  <= 1'b0;
      cpu_s_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_out_q   <= '0;
      res_nzv_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      cpu_in_q    <= cpu_in_d;
      cpu_load_q  <= cpu_load_d;
      cpu_s_q     <= cpu_s_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_out_q   <= res_out_d;
      res_nzv_q   <= res_nzv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cpu_in    = cpu_in_q;
  assign cpu_load  = cpu_load_q;
  assign cpu_s     = cpu_s_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_out   = res_out_q;
  assign res_nzv   = res_nzv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
